gated_deintegrator: RTL
=======================

GATED_DEINTEGRATOR -- requirements
Module: gated_deintegrator

Interface
REQ-001 The module SHALL have parameter P_NBITS_DATA_IN, default 24: width of the integrated input stream y.
REQ-002 The module SHALL have parameter P_NBITS_DATA_OUT, default 16: width of the recovered sample a.
REQ-003 The module SHALL have parameter P_NBITS_DELAY_ADDR, default 9: delay RAM address width, giving depth 2^P_NBITS_DELAY_ADDR.
REQ-004 The module SHALL have one clock and an asynchronous, active-low reset: clk is the clock and rst_n is the reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 init_wr  input  1  one-cycle pulse that loads init_y and starts the RAM clear.
REQ-008 init_y  input  P_NBITS_DATA_IN  value loaded into y_prev on init_wr.
REQ-009 delay_len  input  P_NBITS_DELAY_ADDR  window length L; sampled only on init_wr.
REQ-010 wr  input  1  strobe qualifying y, at most one per cycle.
REQ-011 y  input  P_NBITS_DATA_IN  integrator output sample.
REQ-012 a  output  P_NBITS_DATA_OUT  recovered sample.
REQ-013 a_valid  output  1  one-cycle strobe qualifying a.
REQ-014 busy  output  1  high during the clear sweep; wr is ignored while busy is high.

Function
REQ-015 The block SHALL invert the moving sum y[n]=y[n-1]+a[n]-a[n-L] by computing a[n]=(y[n]-y_prev)+a[n-L].
REQ-016 The FSM SHALL have three states: S_IDLE (after reset), S_CLEAR and S_RUN.
REQ-017 FSM transitions: init_wr in any state goes to S_CLEAR; S_CLEAR goes to S_RUN after 2^P_NBITS_DELAY_ADDR write cycles; S_RUN stays in S_RUN.
REQ-018 In S_CLEAR the block SHALL write 0 to RAM addresses 0..2^N-1, one per cycle, with busy=1.
REQ-019 init_wr asserted during S_CLEAR SHALL restart the sweep at address 0 and reload y_prev and L.
REQ-020 wr SHALL be ignored in S_IDLE and S_CLEAR: no a_valid and no state change.
REQ-021 Latched L SHALL be clamped to a minimum of 2; values 0 and 1 SHALL behave as 2.
REQ-022 Write address SHALL increment on each accepted wr and wrap from L-1 to 0; the read address SHALL return the entry written L accepted samples earlier.
REQ-023 The difference y-y_prev SHALL be computed modulo 2^P_NBITS_DATA_IN; y_prev SHALL update to y on each accepted wr.
REQ-024 a_valid SHALL assert exactly 2 clk cycles after an accepted wr, for 1 cycle.
REQ-025 Back-to-back wr on every cycle SHALL be supported with no loss; the a[n-L] feedback SHALL be forwarded when L=2.
REQ-026 The recovered a[n] SHALL be written into RAM in the cycle a_valid is high.
REQ-027 The first L outputs after a clear SHALL use a[n-L]=0.

Reset
REQ-028 rst_n low SHALL immediately force: FSM=S_IDLE, a=0, a_valid=0, busy=0, y_prev=0, addresses=0, L=2.
REQ-029 RAM contents SHALL NOT be reset; valid output requires an init_wr after reset.
REQ-030 Reset mid-clear or mid-run SHALL abort and discard any in-flight sample.

Configuration
REQ-031 With GATED_DEINTEGRATOR_SAT_EN defined, a SHALL clamp to 0 when the full-width signed result is negative and to 2^P_NBITS_DATA_OUT-1 when it exceeds that value.
REQ-032 Without GATED_DEINTEGRATOR_SAT_EN, a SHALL be the low P_NBITS_DATA_OUT bits (wrap), and the RAM SHALL store the same value in both cases.

Verification
REQ-033 Scenario: init_wr with init_y=0 and L=4, wait for busy to fall, then y=1,3,6,10,14,18 -> a=1,2,3,4,5,6, each 2 cycles after its wr.
REQ-034 Scenario: same stream with wr every other cycle -> identical a values with identical 2-cycle latency.
REQ-035 Scenario: delay_len=1, a constant 5 stream integrated with L=2 (y=5,10,10,10) -> a=5,5,5,5.
REQ-036 Scenario: y=0 then y=0xFFFFFF with init_y=0 and L=4 -> wrapped diff gives 0xFFFF without the macro and 0 with the macro.
REQ-037 Scenario: rst_n low during S_CLEAR -> busy=0 and a_valid=0 immediately, and wr is ignored until a new init_wr completes its clear.
REQ-038 Scenario: wr during busy -> no a_valid and y_prev unchanged.

Source files
------------

// File: rtl/gated_deintegrator.sv
// Gated de-integrator: recovers a[n] = (y[n] - y[n-1]) + a[n-L] from a moving-sum stream.
// Optional output saturation is enabled by defining GATED_DEINTEGRATOR_SAT_EN.
module gated_deintegrator #(
   parameter int unsigned P_NBITS_DATA_IN    = 24,
   parameter int unsigned P_NBITS_DATA_OUT   = 16,
   parameter int unsigned P_NBITS_DELAY_ADDR = 9
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          init_wr,
   input  logic [P_NBITS_DATA_IN-1:0]    init_y,
   input  logic [P_NBITS_DELAY_ADDR-1:0] delay_len,
   input  logic                          wr,
   input  logic [P_NBITS_DATA_IN-1:0]    y,
   output logic [P_NBITS_DATA_OUT-1:0]   a,
   output logic                          a_valid,
   output logic                          busy
);

   localparam int unsigned IW    = P_NBITS_DATA_IN;
   localparam int unsigned OW    = P_NBITS_DATA_OUT;
   localparam int unsigned AW    = P_NBITS_DELAY_ADDR;
   localparam int unsigned Depth = 2 ** AW;
   localparam int unsigned SumW  = IW + 2;

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN} state_e;

   state_e          state_q;
   logic            busy_q;
   logic [AW-1:0]   clr_addr_q;
   logic [AW-1:0]   len_q;
   logic [AW-1:0]   wptr_q;
   logic [IW-1:0]   y_prev_q;
   logic            s1_valid_q;
   logic [IW-1:0]   s1_diff_q;
   logic [AW-1:0]   s1_addr_q;
   logic            a_valid_q;
   logic [OW-1:0]   a_q;
   logic [AW-1:0]   st_addr_q;
   logic [OW-1:0]   st_data_q;
   logic [OW-1:0]   rd_q;

   logic [OW-1:0]   mem [Depth];

   logic [AW-1:0]   len_clamped;
   logic signed [SumW-1:0] sum;
   logic [OW-1:0]   a_wrap;
   logic [OW-1:0]   a_out;
   logic            mem_we;
   logic [AW-1:0]   mem_waddr;
   logic [OW-1:0]   mem_wdata;
   logic [OW-1:0]   rd_next;

   always_comb begin
      len_clamped = (delay_len < AW'(2)) ? AW'(2) : delay_len;
   end

   // Difference is signed modulo 2^IW; the delayed sample is unsigned.
   always_comb begin
      sum    = $signed({{2{s1_diff_q[IW-1]}}, s1_diff_q})
             + $signed({{(SumW-OW){1'b0}}, rd_q});
      a_wrap = sum[OW-1:0];
`ifdef GATED_DEINTEGRATOR_SAT_EN
      if (sum[SumW-1]) begin
         a_out = '0;
      end else if (|sum[SumW-2:OW]) begin
         a_out = '1;
      end else begin
         a_out = a_wrap;
      end
`else
      a_out = a_wrap;
`endif
   end

   // Single write port: the clear sweep owns it, otherwise the recovered sample.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = st_addr_q;
      mem_wdata = st_data_q;
      if (state_q == S_CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = clr_addr_q;
         mem_wdata = '0;
      end else if (state_q == S_RUN && a_valid_q) begin
         mem_we = 1'b1;
      end
   end

   // Forward a same-edge write so L=2 back-to-back sees the fresh a[n-L].
   always_comb begin
      rd_next = (mem_we && mem_waddr == wptr_q) ? mem_wdata : mem[wptr_q];
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
      rd_q <= rd_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         busy_q     <= 1'b0;
         clr_addr_q <= '0;
         len_q      <= AW'(2);
         wptr_q     <= '0;
         y_prev_q   <= '0;
         s1_valid_q <= 1'b0;
         s1_diff_q  <= '0;
         s1_addr_q  <= '0;
         a_valid_q  <= 1'b0;
         a_q        <= '0;
         st_addr_q  <= '0;
         st_data_q  <= '0;
      end else begin
         s1_valid_q <= 1'b0;
         a_valid_q  <= 1'b0;
         if (init_wr) begin
            state_q    <= S_CLEAR;
            busy_q     <= 1'b1;
            clr_addr_q <= '0;
            y_prev_q   <= init_y;
            len_q      <= len_clamped;
            wptr_q     <= '0;
         end else begin
            unique case (state_q)
               S_IDLE: begin
               end
               S_CLEAR: begin
                  clr_addr_q <= clr_addr_q + AW'(1);
                  if (clr_addr_q == {AW{1'b1}}) begin
                     state_q <= S_RUN;
                     busy_q  <= 1'b0;
                  end
               end
               S_RUN: begin
                  if (wr) begin
                     s1_valid_q <= 1'b1;
                     s1_diff_q  <= y - y_prev_q;
                     s1_addr_q  <= wptr_q;
                     y_prev_q   <= y;
                     wptr_q     <= (wptr_q == len_q - AW'(1)) ? '0 : wptr_q + AW'(1);
                  end
                  if (s1_valid_q) begin
                     a_valid_q <= 1'b1;
                     a_q       <= a_out;
                     st_addr_q <= s1_addr_q;
                     st_data_q <= a_wrap;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign a       = a_q;
   assign a_valid = a_valid_q;
   assign busy    = busy_q;

endmodule
